// File: rtl/pe_array_sched.sv
// PE-array layer sequencer: mode broadcast, filter load, then throttled ifmap rounds with conv_done sync.
// Latency: start -> first filter acceptance 2 cycles; optional WAIT_DONE watchdog under PE_SCHED_TIMEOUT_EN.
// Backpressure: filter ready follows valid in LOAD; ifmap ready is withheld while the target PE is full.
module pe_array_sched #(
    parameter int NUM_PE         = 24,
    parameter int IDX_W          = 5,
    parameter int CNT_W          = 10,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode_cfg,
    input  logic [CNT_W-1:0]  num_filt_pkts,
    input  logic [CNT_W-1:0]  num_if_pkts,
    input  logic [CNT_W-1:0]  num_rounds,
    input  logic              fbuf_valid,
    output logic              fbuf_ready,
    input  logic              ibuf_valid,
    input  logic [IDX_W-1:0]  ibuf_idx,
    output logic              ibuf_ready,
    input  logic [NUM_PE-1:0] pe_full,
    input  logic [NUM_PE-1:0] pe_conv_done,
    input  logic [NUM_PE-1:0] pe_error,
    output logic [1:0]        mode_out,
    output logic              change_mode,
    output logic [1:0]        op_stage,
    output logic              filt_pkt_valid,
    output logic              if_pkt_valid,
    output logic              conv_continue,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_LOAD, S_CONV, S_WAIT, S_NEXT, S_ERR
    } state_t;

    state_t           state_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] nf_q, ni_q, nr_q;
    logic [CNT_W-1:0] filt_cnt_q, if_cnt_q, round_cnt_q;
    logic             arm_q, chg_q, cont_q, done_q, err_q;
    logic             tgt_full, any_err;

`ifdef PE_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wd_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    // Indices beyond the array never match, so they are treated as not full.
    always_comb begin
        tgt_full = 1'b0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (ibuf_idx == IDX_W'(i)) tgt_full = pe_full[i];
        end
    end

    assign any_err        = |pe_error;
    assign fbuf_ready     = (state_q == S_LOAD) & fbuf_valid;
    assign ibuf_ready     = (state_q == S_CONV) & ibuf_valid & ~tgt_full;
    assign filt_pkt_valid = fbuf_ready;
    assign if_pkt_valid   = ibuf_ready;
    assign busy           = (state_q != S_IDLE);
    assign mode_out       = mode_q;
    assign change_mode    = chg_q;
    assign conv_continue  = cont_q;
    assign done           = done_q;
    assign err            = err_q;

    always_comb begin
        case (state_q)
            S_LOAD:                 op_stage = 2'd1;
            S_CONV, S_WAIT, S_NEXT: op_stage = 2'd2;
            default:                op_stage = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'd0;
            nf_q        <= '0;
            ni_q        <= '0;
            nr_q        <= '0;
            filt_cnt_q  <= '0;
            if_cnt_q    <= '0;
            round_cnt_q <= '0;
            arm_q       <= 1'b0;
            chg_q       <= 1'b0;
            cont_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef PE_SCHED_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            chg_q  <= 1'b0;
            cont_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q      <= mode_cfg;
                        nf_q        <= num_filt_pkts;
                        ni_q        <= num_if_pkts;
                        nr_q        <= num_rounds;
                        filt_cnt_q  <= '0;
                        if_cnt_q    <= '0;
                        round_cnt_q <= '0;
                        chg_q       <= 1'b1;
                        state_q     <= S_CFG;
                    end
                end
                S_CFG: state_q <= S_LOAD;
                S_LOAD: begin
                    if (any_err) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else if (fbuf_ready) begin
                        if (filt_cnt_q == nf_q - CNT_W'(1)) begin
                            filt_cnt_q <= '0;
                            state_q    <= S_CONV;
                        end else begin
                            filt_cnt_q <= filt_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_CONV: begin
                    if (any_err) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else if (ibuf_ready) begin
                        if (if_cnt_q == ni_q - CNT_W'(1)) begin
                            arm_q   <= 1'b0;
`ifdef PE_SCHED_TIMEOUT_EN
                            wd_q    <= '0;
`endif
                            state_q <= S_WAIT;
                        end else begin
                            if_cnt_q <= if_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    // arm_q hides conv_done still asserted from the previous round.
                    arm_q <= 1'b1;
                    if (any_err) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else if (arm_q && (&pe_conv_done)) begin
                        round_cnt_q <= round_cnt_q + CNT_W'(1);
                        if (round_cnt_q + CNT_W'(1) == nr_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            cont_q  <= 1'b1;
                            state_q <= S_NEXT;
                        end
                    end
`ifdef PE_SCHED_TIMEOUT_EN
                    else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
`endif
                end
                S_NEXT: begin
                    if (any_err) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        if_cnt_q <= '0;
                        state_q  <= S_CONV;
                    end
                end
                S_ERR:   state_q <= S_ERR;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
